multi_port_register_file: RTL and testbench
===========================================

MULTI_PORT_REGISTER_FILE -- requirements
Module: multi_port_register_file

Interface
REQ-001 The block SHALL expose these parameters:
- DATA_WIDTH, default 16, word width in bits.
- ADDR_WIDTH, default 6, address width; depth = 2**ADDR_WIDTH.
- NUM_READ, default 2, number of independent read ports (>=1).

REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- Clock  in  1  single clock, rising-edge active.
- Reset  in  1  asynchronous, active-high reset.
- WriteEnable  in  1  write request.
- WriteAddress  in  ADDR_WIDTH  write target.
- WriteData  in  DATA_WIDTH  write value.
- ReadAddress  in  NUM_READ x ADDR_WIDTH  per-port read address.
- ReadData  out  NUM_READ x DATA_WIDTH  per-port read value.
- ClearRequest  in  1  start a full-array clear sweep.
- Busy  out  1  clear sweep in progress.
- WriteIgnored  out  1  registered one-cycle pulse: a write was dropped.

Function
REQ-003 Reads SHALL be combinational, with zero latency: ReadData[i] = array[ReadAddress[i]] while Busy=0.
REQ-004 Writes SHALL update array[WriteAddress] on the rising Clock edge when WriteEnable=1 and Busy=0; the new value is visible on reads after that edge.
REQ-005 All read ports SHALL be independent; identical addresses on several ports return identical data.
REQ-006 The clear sequencer SHALL have two states, IDLE and CLEAR, and a ClearIndex counter of ADDR_WIDTH bits.
REQ-007 In CLEAR, each cycle SHALL write 0 to array[ClearIndex] and increment ClearIndex.
REQ-008 On the cycle that clears index 2**ADDR_WIDTH-1, the sequencer SHALL go to IDLE; Busy drops after that edge. A sweep lasts exactly 2**ADDR_WIDTH cycles (64 at default).
REQ-009 In IDLE, ClearRequest=1 SHALL enter CLEAR with ClearIndex=0 on the next edge.
REQ-010 ClearRequest in CLEAR SHALL be ignored; the sweep is neither restarted nor extended.
REQ-011 Busy SHALL equal 1 exactly while state is CLEAR.
REQ-012 While Busy=1, every ReadData output SHALL be 0.
REQ-013 WriteEnable=1 while Busy=1 SHALL leave the array unchanged and SHALL assert WriteIgnored for the following cycle only.
REQ-014 WriteEnable=1 and ClearRequest=1 in the same IDLE cycle SHALL perform the write; the subsequent sweep then zeroes it.
REQ-015 ClearIndex SHALL wrap to 0 on exit from CLEAR; no out-of-range index is generated.

Reset
REQ-016 Reset assertion SHALL immediately force state=CLEAR, ClearIndex=0, Busy=1, WriteIgnored=0, and ReadData all 0.
REQ-017 Array contents SHALL NOT be reset directly; they are zeroed by the post-reset sweep, so Busy stays 1 for 2**ADDR_WIDTH cycles after Reset deasserts.
REQ-018 Reset asserted mid-sweep SHALL restart the sweep from index 0.

Configuration
REQ-019 With REGFILE_BYPASS_EN defined, a read whose address equals WriteAddress while an accepted write (WriteEnable=1, Busy=0) is in progress SHALL return WriteData combinationally in that same cycle.
REQ-020 With REGFILE_BYPASS_EN undefined, that read SHALL return the pre-write array content until the edge.

Structure
REQ-021 Package regfile_pkg SHALL hold the clear_state_t enum (IDLE, CLEAR) and the default DATA_WIDTH, ADDR_WIDTH and NUM_READ constants.
REQ-022 The clear FSM and ClearIndex counter SHALL be the sub-module regfile_clear_seq; the array, read muxing and bypass logic stay in the top.

Verification
REQ-023 Bench SHALL cover at least the following scenarios (default parameters unless stated):
- Post-reset sweep: pulse Reset, then attempt write 16'hF0F0 to address 15 at cycle 10 -> Busy=1 for 64 cycles, WriteIgnored pulses once, address 15 reads 0 after Busy falls.
- Basic write/read: write 16'hF0F0 to address 15 -> ReadData[0]=16'hF0F0 at address 15 and ReadData[1]=0 at address 22 the next cycle.
- Overwrite and disable: write 0 to address 15, then WriteEnable=0 with WriteData=16'hAAAA -> address 15 reads 0.
- Clear request: fill addresses 0..63 with their index, then pulse ClearRequest -> Busy=1 for exactly 64 cycles, all addresses read 0 afterwards; a second ClearRequest at cycle 30 does not extend the sweep.
- Bypass: write 16'h1234 to address 7 while ReadAddress[0]=7 -> same cycle returns 16'h1234 with REGFILE_BYPASS_EN, old value without it.
- Parameter sweep: DATA_WIDTH=32, ADDR_WIDTH=3, NUM_READ=4 -> sweep lasts 8 cycles; all 4 ports read 32'hDEADBEEF from address 5 after it is written.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the multi-port register file.
package regfile_pkg;

   // Clear sequencer states
   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clear_state_t;

   // Default geometry
   localparam int unsigned DEFAULT_DATA_WIDTH = 16;
   localparam int unsigned DEFAULT_ADDR_WIDTH = 6;
   localparam int unsigned DEFAULT_NUM_READ   = 2;

endpackage : regfile_pkg

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks ClearIndex over every array entry once per sweep.
// Reset lands in CLEAR so the array is zeroed after every reset.
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  ClearRequest,
   output logic                  Busy,
   output logic [ADDR_WIDTH-1:0] ClearIndex
);

   localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = '1;

   clear_state_t          state;
   clear_state_t          nextState;
   logic [ADDR_WIDTH-1:0] nextIndex;

   // State and index registers; reset restarts the sweep from index 0
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state      <= CLEAR;
         ClearIndex <= '0;
      end else begin
         state      <= nextState;
         ClearIndex <= nextIndex;
      end
   end

   // Next-state logic; the index wraps to 0 naturally when the last entry is cleared
   always_comb begin
      nextState = state;
      nextIndex = ClearIndex;
      unique case (state)
         IDLE: begin
            if (ClearRequest) begin
               nextState = CLEAR;
               nextIndex = '0;
            end
         end
         CLEAR: begin
            nextIndex = ClearIndex + 1'b1;
            if (ClearIndex == LAST_INDEX) begin
               nextState = IDLE;
            end
         end
         default: begin
            nextState = CLEAR;
            nextIndex = '0;
         end
      endcase
   end

   // Output decode
   always_comb begin
      Busy = (state == CLEAR);
   end

endmodule : regfile_clear_seq

// File: rtl/multi_port_register_file.sv
// Register file: one write port, NUM_READ combinational read ports and a
// sequenced clear sweep that also runs after every reset.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
module multi_port_register_file
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int unsigned NUM_READ   = DEFAULT_NUM_READ
) (
   input  logic                                Clock,
   input  logic                                Reset,
   input  logic                                WriteEnable,
   input  logic [ADDR_WIDTH-1:0]               WriteAddress,
   input  logic [DATA_WIDTH-1:0]               WriteData,
   input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0] ReadAddress,
   output logic [NUM_READ-1:0][DATA_WIDTH-1:0] ReadData,
   input  logic                                ClearRequest,
   output logic                                Busy,
   output logic                                WriteIgnored
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] memArray [DEPTH];
   logic [ADDR_WIDTH-1:0] clearIndex;
   logic                  writeAccepted;

   regfile_clear_seq #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) uClearSeq (
      .Clock        (Clock),
      .Reset        (Reset),
      .ClearRequest (ClearRequest),
      .Busy         (Busy),
      .ClearIndex   (clearIndex)
   );

   // A write only lands when no sweep is running
   always_comb begin
      writeAccepted = WriteEnable & ~Busy;
   end

   // Array update: sweep zeroing takes priority over user writes
   always_ff @(posedge Clock) begin
      if (Busy) begin
         memArray[clearIndex] <= '0;
      end else if (writeAccepted) begin
         memArray[WriteAddress] <= WriteData;
      end
   end

   // One-cycle pulse flagging a write dropped because of a sweep
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         WriteIgnored <= 1'b0;
      end else begin
         WriteIgnored <= WriteEnable & Busy;
      end
   end

   // Combinational read ports, forced to zero during a sweep
   always_comb begin
      ReadData = '0;
      for (int unsigned i = 0; i < NUM_READ; i++) begin
         if (!Busy) begin
            ReadData[i] = memArray[ReadAddress[i]];
`ifdef REGFILE_BYPASS_EN
            if (writeAccepted && (ReadAddress[i] == WriteAddress)) begin
               ReadData[i] = WriteData;
            end
`else
            if (writeAccepted && (ReadAddress[i] == WriteAddress)) begin
               ReadData[i] = memArray[ReadAddress[i]];
            end
`endif
         end
      end
   end

endmodule : multi_port_register_file

// File: tb/tb_multi_port_register_file.sv
module tb_multi_port_register_file;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic              rstA, weA, crA, busyA, wiA;
  logic [5:0]        waA;
  logic [15:0]       wdA;
  logic [1:0][5:0]   raA;
  logic [1:0][15:0]  rdA;

  logic              rstB, weB, crB, busyB, wiB;
  logic [2:0]        waB;
  logic [31:0]       wdB;
  logic [3:0][2:0]   raB;
  logic [3:0][31:0]  rdB;

  multi_port_register_file #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (6),
    .NUM_READ   (2)
  ) dutA (
    .Clock        (Clock),
    .Reset        (rstA),
    .WriteEnable  (weA),
    .WriteAddress (waA),
    .WriteData    (wdA),
    .ReadAddress  (raA),
    .ReadData     (rdA),
    .ClearRequest (crA),
    .Busy         (busyA),
    .WriteIgnored (wiA)
  );

  multi_port_register_file #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (3),
    .NUM_READ   (4)
  ) dutB (
    .Clock        (Clock),
    .Reset        (rstB),
    .WriteEnable  (weB),
    .WriteAddress (waB),
    .WriteData    (wdB),
    .ReadAddress  (raB),
    .ReadData     (rdB),
    .ClearRequest (crB),
    .Busy         (busyB),
    .WriteIgnored (wiB)
  );

  typedef enum int {K_RDA, K_BUSYA, K_WIGNA, K_RDB, K_BUSYB} kind_t;
  typedef struct {
    string       name;
    kind_t       kind;
    int unsigned port;
    logic [31:0] exp;
  } exp_t;

  exp_t sbQ[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic pushExp(input string name, input kind_t kind,
                         input int unsigned port, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.port = port;
    e.exp  = exp;
    sbQ.push_back(e);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  always @(negedge Clock) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      case (e.kind)
        K_RDA:   act = {16'h0, rdA[e.port]};
        K_BUSYA: act = {31'h0, busyA};
        K_WIGNA: act = {31'h0, wiA};
        K_RDB:   act = rdB[e.port];
        K_BUSYB: act = {31'h0, busyB};
        default: act = 'x;
      endcase
      vectors++;
      if (act !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [15:0] bypassExp;
    int          w;
    rstA = 1'b1; weA = 1'b0; crA = 1'b0; waA = '0; wdA = '0; raA = '0;
    rstB = 1'b1; weB = 1'b0; crB = 1'b0; waB = '0; wdB = '0; raB = '0;
    step();
    step();

    pushExp("rst_busy", K_BUSYA, 0, 32'd1);
    pushExp("rst_wign", K_WIGNA, 0, 32'd0);
    pushExp("rst_rd0",  K_RDA,   0, 32'd0);
    pushExp("rst_rd1",  K_RDA,   1, 32'd0);
    rstA = 1'b0;
    raA[0] = 6'd15;
    raA[1] = 6'd5;

    for (int c = 0; c < 64; c++) begin
      pushExp("sweep_busy", K_BUSYA, 0, 32'd1);
      pushExp("sweep_rd0",  K_RDA,   0, 32'd0);
      weA = 1'b0;
      if (c == 10) begin
        weA = 1'b1; waA = 6'd15; wdA = 16'hF0F0;
      end
      if (c == 40) begin
        weA = 1'b1; waA = 6'd5; wdA = 16'hBEEF;
      end
      pushExp("sweep_wign", K_WIGNA, 0, (c == 11 || c == 41) ? 32'd1 : 32'd0);
      step();
    end
    weA = 1'b0;
    pushExp("sweep_end_busy", K_BUSYA, 0, 32'd0);
    pushExp("sweep_end_wign", K_WIGNA, 0, 32'd0);
    pushExp("sweep_addr15",   K_RDA,   0, 32'd0);
    pushExp("sweep_addr5",    K_RDA,   1, 32'd0);
    step();

    weA = 1'b1; waA = 6'd15; wdA = 16'hF0F0;
    raA[0] = 6'd22; raA[1] = 6'd22;
    step();
    weA = 1'b0;
    raA[0] = 6'd15; raA[1] = 6'd22;
    pushExp("basic_rd0", K_RDA, 0, 32'h0000F0F0);
    pushExp("basic_rd1", K_RDA, 1, 32'd0);
    step();
    raA[1] = 6'd15;
    pushExp("same_addr_rd0", K_RDA, 0, 32'h0000F0F0);
    pushExp("same_addr_rd1", K_RDA, 1, 32'h0000F0F0);
    step();

    raA[0] = 6'd22; raA[1] = 6'd22;
    weA = 1'b1; waA = 6'd15; wdA = 16'h0000;
    step();
    weA = 1'b0; wdA = 16'hAAAA;
    raA[0] = 6'd15;
    pushExp("overwrite_rd0", K_RDA, 0, 32'd0);
    step();
    pushExp("we0_rd0", K_RDA, 0, 32'd0);
    step();

    raA[0] = 6'd62; raA[1] = 6'd62;
    for (int i = 0; i < 64; i++) begin
      weA = 1'b1; waA = 6'(i); wdA = 16'(i);
      step();
    end
    weA = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raA[0] = 6'(i); raA[1] = 6'(i + 32);
      pushExp("fill_rd0", K_RDA, 0, 32'(i));
      pushExp("fill_rd1", K_RDA, 1, 32'(i + 32));
      step();
    end

    raA[0] = 6'd63;
    crA = 1'b1;
    pushExp("clr_idle_busy", K_BUSYA, 0, 32'd0);
    pushExp("clr_pre_rd0",   K_RDA,   0, 32'd63);
    step();
    crA = 1'b0;
    for (int c = 0; c < 64; c++) begin
      crA = (c == 29) ? 1'b1 : 1'b0;
      pushExp("clr_busy", K_BUSYA, 0, 32'd1);
      pushExp("clr_rd0",  K_RDA,   0, 32'd0);
      step();
    end
    crA = 1'b0;
    pushExp("clr_end_busy", K_BUSYA, 0, 32'd0);
    step();
    for (int i = 0; i < 32; i++) begin
      raA[0] = 6'(i); raA[1] = 6'(i + 32);
      pushExp("clr_zero_rd0", K_RDA, 0, 32'd0);
      pushExp("clr_zero_rd1", K_RDA, 1, 32'd0);
      step();
    end

`ifdef REGFILE_BYPASS_EN
    bypassExp = 16'h1234;
`else
    bypassExp = 16'h0000;
`endif
    raA[0] = 6'd7; raA[1] = 6'd8;
    weA = 1'b1; waA = 6'd7; wdA = 16'h1234;
    pushExp("bypass_same", K_RDA, 0, {16'h0, bypassExp});
    pushExp("bypass_other", K_RDA, 1, 32'd0);
    step();
    weA = 1'b0;
    pushExp("bypass_after", K_RDA, 0, 32'h00001234);
    step();

    crA = 1'b1;
    step();
    crA = 1'b0;
    for (w = 0; w < 19; w++) step();
    weA = 1'b1; waA = 6'd2; wdA = 16'h7777;
    step();
    weA = 1'b0;
    rstA = 1'b1;
    pushExp("midrst_busy", K_BUSYA, 0, 32'd1);
    pushExp("midrst_wign", K_WIGNA, 0, 32'd0);
    pushExp("midrst_rd0",  K_RDA,   0, 32'd0);
    step();
    rstA = 1'b0;
    for (int c = 0; c < 64; c++) begin
      pushExp("midrst_sweep_busy", K_BUSYA, 0, 32'd1);
      step();
    end
    pushExp("midrst_end_busy", K_BUSYA, 0, 32'd0);
    pushExp("midrst_rd0_zero", K_RDA,   0, 32'd0);
    step();

    rstB = 1'b1;
    pushExp("b_rst_busy", K_BUSYB, 0, 32'd1);
    step();
    rstB = 1'b0;
    for (int c = 0; c < 8; c++) begin
      pushExp("b_sweep_busy", K_BUSYB, 0, 32'd1);
      step();
    end
    pushExp("b_end_busy", K_BUSYB, 0, 32'd0);
    weB = 1'b1; waB = 3'd5; wdB = 32'hDEADBEEF;
    raB = '0;
    step();
    weB = 1'b0;
    for (int p = 0; p < 4; p++) raB[p] = 3'd5;
    for (int p = 0; p < 4; p++) pushExp("b_port_rd", K_RDB, p, 32'hDEADBEEF);
    step();

    for (int unsigned p = 0; p < 4; p++) begin
      vectors++;
      if (rdB[p] !== 32'hDEADBEEF) begin
        miscompares++;
        $display("FAIL b_direct_rd[%0d]: got %h, expected %h", p, rdB[p], 32'hDEADBEEF);
      end
    end
    vectors++;
    if (busyB !== 1'b0) begin
      miscompares++;
      $display("FAIL b_direct_busy: got %b, expected 0", busyB);
    end
    vectors++;
    if (wiB !== 1'b0) begin
      miscompares++;
      $display("FAIL b_direct_wign: got %b, expected 0", wiB);
    end

    @(negedge Clock);
    #1;
    vectors++;
    if (sbQ.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard: %0d expectations left unchecked", sbQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_multi_port_register_file
